// File: rtl/ififo16_pkg.sv
// Shared sizing constants and pointer/count types for the 16-entry FWFT FIFO.
package ififo16_pkg;

    localparam int unsigned IFIFO_DEPTH = 16;
    localparam int unsigned IFIFO_PTR_W = 4;
    localparam int unsigned IFIFO_CNT_W = 5;

    typedef logic [IFIFO_PTR_W-1:0] ififo_ptr_t;
    typedef logic [IFIFO_CNT_W-1:0] ififo_cnt_t;

endpackage

// File: rtl/ififo16_mem.sv
// 16 x DATA_WIDTH register array: synchronous write port, asynchronous read port.
module ififo16_mem
    import ififo16_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  we,
    input  ififo_ptr_t            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  ififo_ptr_t            raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [IFIFO_DEPTH];

    // Storage is deliberately not reset; the top-level zero mux hides stale words.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ififo16.sv
// 16-entry first-word-fall-through FIFO; head word shown on o_data, zero while empty.
// Define IFIFO16_ERR_FLAGS_EN to add sticky o_overrun / o_underrun outputs.
module ififo16
    import ififo16_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_enq,
    input  logic                  i_deq,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full
`ifdef IFIFO16_ERR_FLAGS_EN
    ,
    output logic                  o_overrun,
    output logic                  o_underrun
`endif
);

    ififo_ptr_t            wr_ptr;
    ififo_ptr_t            rd_ptr;
    ififo_cnt_t            cnt;
    logic                  do_enq;
    logic                  do_deq;
    logic [DATA_WIDTH-1:0] head;

    assign o_empty = (cnt == '0);
    assign o_full  = (cnt == IFIFO_CNT_W'(IFIFO_DEPTH));

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign do_deq = i_deq & ~o_empty;
    assign do_enq = i_enq & (~o_full | do_deq);

    ififo16_mem #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .i_clk(i_clk),
        .we   (do_enq),
        .waddr(wr_ptr),
        .wdata(i_data),
        .raddr(rd_ptr),
        .rdata(head)
    );

    assign o_data = o_empty ? '0 : head;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + IFIFO_PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + IFIFO_PTR_W'(1);
            end
            cnt <= cnt + IFIFO_CNT_W'(do_enq) - IFIFO_CNT_W'(do_deq);
        end
    end

`ifdef IFIFO16_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            if (i_enq & o_full & ~do_deq) begin
                o_overrun <= 1'b1;
            end
            if (i_deq & o_empty) begin
                o_underrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ififo16.sv
// Self-checking bench for ififo16: queue-based reference model plus directed vectors.
module tb_ififo16;

    localparam int unsigned DW = 32;

    logic          i_clk;
    logic          i_rst;
    logic [DW-1:0] i_data;
    logic          i_enq;
    logic          i_deq;
    logic [DW-1:0] o_data;
    logic          o_empty;
    logic          o_full;
`ifdef IFIFO16_ERR_FLAGS_EN
    logic          o_overrun;
    logic          o_underrun;
`endif

    ififo16 #(DW) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .i_enq  (i_enq),
        .i_deq  (i_deq),
        .o_data (o_data),
        .o_empty(o_empty),
        .o_full (o_full)
`ifdef IFIFO16_ERR_FLAGS_EN
        ,
        .o_overrun (o_overrun),
        .o_underrun(o_underrun)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: contents in order, plus sticky error bits.
    logic [DW-1:0] q[$];
    logic          m_ovr;
    logic          m_und;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every negedge: DUT outputs must match the model's head/flags.
    always @(negedge i_clk) begin
        check("cyc_data", o_data, (q.size() != 0) ? q[0] : '0);
        check("cyc_empty", DW'(o_empty), DW'(q.size() == 0));
        check("cyc_full", DW'(o_full), DW'(q.size() == 16));
`ifdef IFIFO16_ERR_FLAGS_EN
        check("cyc_ovr", DW'(o_overrun), DW'(m_ovr));
        check("cyc_und", DW'(o_underrun), DW'(m_und));
`endif
    end

    // Drive one edge worth of requests, advance the model, return at the following negedge.
    task automatic step(input logic e, input logic d, input logic [DW-1:0] x);
        bit full_b, empty_b, dd, de;
        i_enq  = e;
        i_deq  = d;
        i_data = x;
        @(posedge i_clk);
        empty_b = (q.size() == 0);
        full_b  = (q.size() == 16);
        dd = d && !empty_b;
        de = e && (!full_b || dd);
        if (e && full_b && !dd) m_ovr = 1'b1;
        if (d && empty_b) m_und = 1'b1;
        if (dd) void'(q.pop_front());
        if (de) q.push_back(x);
        @(negedge i_clk);
        i_enq = 1'b0;
        i_deq = 1'b0;
    endtask

    logic [DW-1:0] sent[$];
    int            rx_idx;

    initial begin
        i_rst  = 1'b1;
        i_enq  = 1'b0;
        i_deq  = 1'b0;
        i_data = '0;
        m_ovr  = 1'b0;
        m_und  = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_empty", DW'(o_empty), DW'(1));
        check("rst_full", DW'(o_full), DW'(0));
        check("rst_data", o_data, '0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // FWFT latency
        step(1'b1, 1'b0, 32'h3C);
        check("fwft_data", o_data, 32'h3C);
        check("fwft_empty", DW'(o_empty), DW'(0));
        step(1'b0, 1'b1, '0);
        check("fwft_drain", DW'(o_empty), DW'(1));

        // Fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i));
        check("fill_full", DW'(o_full), DW'(1));
        check("fill_head", o_data, 32'd1);
        step(1'b1, 1'b0, 32'd99);
        check("ovf_full", DW'(o_full), DW'(1));
        check("ovf_head", o_data, 32'd1);
`ifdef IFIFO16_ERR_FLAGS_EN
        check("ovf_flag", DW'(o_overrun), DW'(1));
`endif
        for (int i = 1; i <= 16; i++) begin
            check("drain_seq", o_data, DW'(i));
            step(1'b0, 1'b1, '0);
        end
        check("drain_empty", DW'(o_empty), DW'(1));
        check("drain_data", o_data, '0);

        // Simultaneous enq+deq while full
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b1, 32'd77);
        check("sim_full_head", o_data, 32'd2);
        check("sim_full_flag", DW'(o_full), DW'(1));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0);
        check("sim_full_last", o_data, 32'd77);
        step(1'b0, 1'b1, '0);
        check("sim_full_empty", DW'(o_empty), DW'(1));

        // Underrun and enq+deq on empty
        step(1'b0, 1'b1, '0);
        check("und_empty", DW'(o_empty), DW'(1));
        check("und_data", o_data, '0);
`ifdef IFIFO16_ERR_FLAGS_EN
        check("und_flag", DW'(o_underrun), DW'(1));
`endif
        step(1'b1, 1'b1, 32'd5);
        check("sim_empty_data", o_data, 32'd5);
        check("sim_empty_flag", DW'(o_empty), DW'(0));
        step(1'b0, 1'b1, '0);

        // Wrap-around with occupancy held in 3..7
        rx_idx = 0;
        for (int i = 0; i < 5; i++) begin
            sent.push_back(DW'(32'h1000 + i));
            step(1'b1, 1'b0, DW'(32'h1000 + i));
        end
        for (int i = 0; i < 40; i++) begin
            bit e, d;
            logic [DW-1:0] w;
            case (i % 4)
                0:       begin e = 1; d = 1; end
                1:       begin e = 1; d = (q.size() >= 7); end
                2:       begin d = 1; e = (q.size() <= 3); end
                default: begin e = 1; d = (q.size() >= 7); end
            endcase
            w = DW'(32'h1000 + sent.size());
            if (e) sent.push_back(w);
            if (d) begin
                check("wrap_seq", o_data, sent[rx_idx]);
                rx_idx++;
            end
            step(e, d, w);
            check("wrap_nofull", DW'(o_full), DW'(0));
            check("wrap_noempty", DW'(o_empty), DW'(0));
        end

        // Asynchronous reset mid-cycle with 5 entries stored
        while (q.size() > 5) step(1'b0, 1'b1, '0);
        while (q.size() < 5) step(1'b1, 1'b0, 32'h55);
        #2;
        i_rst = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_und = 1'b0;
        #1;
        check("arst_empty", DW'(o_empty), DW'(1));
        check("arst_full", DW'(o_full), DW'(0));
        check("arst_data", o_data, '0);
`ifdef IFIFO16_ERR_FLAGS_EN
        check("arst_ovr", DW'(o_overrun), DW'(0));
        check("arst_und", DW'(o_underrun), DW'(0));
`endif
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        step(1'b1, 1'b0, 32'hA5);
        check("arst_enq", o_data, 32'hA5);
        check("arst_enq_empty", DW'(o_empty), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ififo16.md
Name: ififo16

Overview:
- 16-entry, first-word-fall-through (FWFT) synchronous FIFO with a parameterised data width.
- Used as the input-A, input-B and output-C buffers around the bitonic merge pipeline.
- Its head word is visible combinationally on o_data, so downstream compare/control logic can inspect it before dequeuing.
- The control logic treats an all-zero head as "no data", so an empty FIFO presents zero on o_data.

Parameters:
- DATA_WIDTH, 32, width in bits of each stored word. The merger instantiates it at 32*128; it is passed positionally as the first parameter.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  DATA_WIDTH  word to enqueue.
- i_enq  input  1  enqueue request, sampled at the rising edge.
- i_deq  input  1  dequeue request, sampled at the rising edge; pops the current head.
- o_data  output  DATA_WIDTH  current head word (FWFT); all zeros while empty.
- o_empty  output  1  high when the FIFO holds 0 entries.
- o_full  output  1  high when the FIFO holds 16 entries.

Behaviour:
- Storage and state:
  - 16 x DATA_WIDTH storage array.
  - 4-bit write pointer wr_ptr and 4-bit read pointer rd_ptr, both wrapping modulo 16.
  - 5-bit occupancy count cnt, range 0..16.
- Reset (async, i_rst=1):
  - wr_ptr=0, rd_ptr=0, cnt=0, so o_empty=1, o_full=0, o_data=0.
  - Storage contents are not cleared.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Flags: combinational decodes of cnt. o_empty=(cnt==0); o_full=(cnt==16). Never both high.
- o_data: combinational. It equals mem[rd_ptr] when cnt!=0, else all zeros.
- Effective operations each rising edge (reset low):
  - do_enq = i_enq & (~o_full | do_deq)
  - do_deq = i_deq & ~o_empty
  - do_enq: mem[wr_ptr]<=i_data; wr_ptr<=wr_ptr+1.
  - do_deq: rd_ptr<=rd_ptr+1.
  - cnt <= cnt + do_enq - do_deq.
- Latency:
  - A word enqueued into an empty FIFO at edge N appears on o_data, with o_empty=0, immediately after edge N.
  - A dequeue at edge N exposes the next word, or zero if the FIFO becomes empty, right after edge N.
- Boundary cases:
  - Full, enq only: write ignored (overrun); state unchanged.
  - Full, enq+deq: both performed; cnt stays 16; the new word lands in the slot just freed.
  - Empty, deq only: ignored (underrun); state unchanged.
  - Empty, enq+deq: deq ignored, enq performed; cnt becomes 1.
  - Non-empty, non-full, enq+deq: both performed; cnt unchanged.
  - Wrap-around: pointers roll over from 15 to 0 seamlessly; ordering is strictly FIFO across the wrap.
- No X may reach o_data: the zero mux covers uninitialised storage while empty.

Optional Feature:
- Macro IFIFO16_ERR_FLAGS_EN.
- When defined:
  - Adds outputs o_overrun (1) and o_underrun (1), sticky error flags cleared only by i_rst.
  - o_overrun sets on any edge with i_enq=1 while full and no effective dequeue.
  - o_underrun sets on any edge with i_deq=1 while empty.
  - Each flag is visible the cycle after the offending edge.
- When undefined: these ports and their logic are absent; data-path behaviour is identical.

Decomposition:
- Shared package ififo16_pkg holds:
  - constants IFIFO_DEPTH=16, IFIFO_PTR_W=4, IFIFO_CNT_W=5;
  - a typedef for the pointer type and one for the count type.
- One natural sub-module: ififo16_mem.
  - 16 x DATA_WIDTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
- Pointer/count/flag logic stays in the top level.

Test Plan:
- Reset: assert i_rst mid-cycle with 5 entries stored -> immediately o_empty=1, o_full=0, o_data=0; the next enq of 0xA5 shows o_data=0xA5 one edge later.
- Fill and overflow: enqueue 1..16 -> o_full=1 after the 16th edge, o_data=1; a 17th enq of 99 is ignored. Then dequeue 16 times -> outputs 1..16 in order, then o_empty=1 and o_data=0.
- FWFT latency: on an empty FIFO, enq 0x3C at edge N -> o_data=0x3C and o_empty=0 right after edge N, with no deq needed.
- Simultaneous at full: full with head=1, assert enq(77)+deq -> o_data=2, o_full stays 1; after 15 more deqs, the last word out is 77.
- Simultaneous at empty plus underrun: on an empty FIFO, deq alone -> no change; then enq(5)+deq together -> cnt=1, o_data=5. With IFIFO16_ERR_FLAGS_EN, o_underrun=1 after the first step.
- Wrap-around: run 40 interleaved enq/deq with occupancy held at 3–7 -> output sequence equals input sequence; o_full and o_empty never assert.
